// File: rtl/axis_rr_arbiter.sv
// Round-robin N:1 valid/ready stream arbiter with packet-locked grants and a
// registered output stage backed by a one-entry skid register.
module axis_rr_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DSIZE       = 32,
  parameter bit          LOCK_PACKET = 1'b1,
  parameter int unsigned SEL_W       = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       s_valid,
  output logic [NUM_PORTS-1:0]       s_ready,
  input  logic [NUM_PORTS*DSIZE-1:0] s_data,
  input  logic [NUM_PORTS-1:0]       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DSIZE-1:0]           m_data,
  output logic                       m_last,
  output logic [SEL_W-1:0]           m_sel,
  output logic                       busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e               r_state, w_state_d;
  logic [SEL_W-1:0]     r_ptr, w_ptr_d;
  logic [SEL_W-1:0]     r_grant, w_grant_d;
  logic [NUM_PORTS-1:0] r_s_ready, w_s_ready_d;

  logic                 r_m_valid, w_m_valid_d;
  logic [DSIZE-1:0]     r_m_data, w_m_data_d;
  logic                 r_m_last, w_m_last_d;
  logic [SEL_W-1:0]     r_m_sel, w_m_sel_d;

  logic                 r_skid_valid, w_skid_valid_d;
  logic [DSIZE-1:0]     r_skid_data, w_skid_data_d;
  logic                 r_skid_last, w_skid_last_d;
  logic [SEL_W-1:0]     r_skid_sel, w_skid_sel_d;

  logic [SEL_W-1:0]     w_scan [NUM_PORTS];
  logic [SEL_W-1:0]     w_arb_idx;
  logic [SEL_W-1:0]     w_grant_inc;
  logic [DSIZE-1:0]     w_beat_data;
  logic                 w_beat_last;
  logic                 w_accept;
  logic                 w_release;
  logic                 w_advance;

  // Scan order starting at the round-robin pointer, wrapping at NUM_PORTS-1.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_scan[i] = SEL_W'((int'(r_ptr) + i) % int'(NUM_PORTS));
    end
  end

  // Walk the scan order backwards so the earliest requester wins.
  always_comb begin
    w_arb_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_valid[w_scan[i]]) begin
        w_arb_idx = w_scan[i];
      end
    end
  end

  always_comb begin
    w_beat_data = '0;
    w_beat_last = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == SEL_W'(i)) begin
        w_beat_data = s_data[i*DSIZE +: DSIZE];
        w_beat_last = s_last[i];
      end
    end
  end

  // r_s_ready is nonzero only on the granted bit, so this is the granted handshake.
  assign w_accept    = |(s_valid & r_s_ready);
  assign w_release   = w_accept & (w_beat_last | ~LOCK_PACKET);
  assign w_advance   = ~r_m_valid | m_ready;
  assign w_grant_inc = (r_grant == SEL_W'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (|s_valid) begin
          w_state_d = StGrant;
          w_grant_d = w_arb_idx;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_state_d = StIdle;
          w_ptr_d   = w_grant_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_m_valid_d    = r_m_valid;
    w_m_data_d     = r_m_data;
    w_m_last_d     = r_m_last;
    w_m_sel_d      = r_m_sel;
    w_skid_valid_d = r_skid_valid;
    w_skid_data_d  = r_skid_data;
    w_skid_last_d  = r_skid_last;
    w_skid_sel_d   = r_skid_sel;
    if (w_advance) begin
      w_m_valid_d    = r_skid_valid | w_accept;
      w_skid_valid_d = 1'b0;
      if (r_skid_valid) begin
        w_m_data_d = r_skid_data;
        w_m_last_d = r_skid_last;
        w_m_sel_d  = r_skid_sel;
      end else if (w_accept) begin
        w_m_data_d = w_beat_data;
        w_m_last_d = w_beat_last;
        w_m_sel_d  = r_grant;
      end
    end else if (w_accept) begin
      w_skid_valid_d = 1'b1;
      w_skid_data_d  = w_beat_data;
      w_skid_last_d  = w_beat_last;
      w_skid_sel_d   = r_grant;
    end
  end

  // Ready is registered from next-state values so it never follows m_ready combinationally.
  always_comb begin
    w_s_ready_d = '0;
    if (w_state_d == StGrant && !w_skid_valid_d) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_grant_d == SEL_W'(i)) begin
          w_s_ready_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_grant      <= '0;
      r_s_ready    <= '0;
      r_m_valid    <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_ptr        <= w_ptr_d;
      r_grant      <= w_grant_d;
      r_s_ready    <= w_s_ready_d;
      r_m_valid    <= w_m_valid_d;
      r_skid_valid <= w_skid_valid_d;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    r_m_data    <= w_m_data_d;
    r_m_last    <= w_m_last_d;
    r_m_sel     <= w_m_sel_d;
    r_skid_data <= w_skid_data_d;
    r_skid_last <= w_skid_last_d;
    r_skid_sel  <= w_skid_sel_d;
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign m_sel   = r_m_sel;
  assign busy    = (r_state == StGrant);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a packet-locked 4-port instance, a per-beat
// 4-port instance and a packet-locked 3-port instance, all on one clock and reset.
module tb_axis_rr_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [3:0]   a_s_valid, a_s_ready, a_s_last;
  logic [127:0] a_s_data;
  logic         a_m_valid, a_m_ready, a_m_last, a_busy;
  logic [31:0]  a_m_data;
  logic [1:0]   a_m_sel;

  logic [3:0]   b_s_valid, b_s_ready, b_s_last;
  logic [127:0] b_s_data;
  logic         b_m_valid, b_m_ready, b_m_last, b_busy;
  logic [31:0]  b_m_data;
  logic [1:0]   b_m_sel;

  logic [2:0]   c_s_valid, c_s_ready, c_s_last;
  logic [95:0]  c_s_data;
  logic         c_m_valid, c_m_ready, c_m_last, c_busy;
  logic [31:0]  c_m_data;
  logic [1:0]   c_m_sel;

  axis_rr_arbiter #(.NUM_PORTS(4), .DSIZE(32), .LOCK_PACKET(1'b1)) u_a (
    .clk(clk), .reset(reset), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_last(a_s_last), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_last(a_m_last), .m_sel(a_m_sel), .busy(a_busy)
  );

  axis_rr_arbiter #(.NUM_PORTS(4), .DSIZE(32), .LOCK_PACKET(1'b0)) u_b (
    .clk(clk), .reset(reset), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_last(b_m_last), .m_sel(b_m_sel), .busy(b_busy)
  );

  axis_rr_arbiter #(.NUM_PORTS(3), .DSIZE(32), .LOCK_PACKET(1'b1)) u_c (
    .clk(clk), .reset(reset), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
    .s_last(c_s_last), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
    .m_last(c_m_last), .m_sel(c_m_sel), .busy(c_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    a_s_valid = '0; a_s_last = '0; a_s_data = '0; a_m_ready = 1'b0;
    b_s_valid = '0; b_s_last = '0; b_s_data = '0; b_m_ready = 1'b0;
    c_s_valid = '0; c_s_last = '0; c_s_data = '0; c_m_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", a_m_valid); end
    checks++; if (a_s_ready !== 4'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0000", a_s_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (c_m_valid !== 1'b0 || c_s_ready !== 3'b0) begin
      errors++; $display("FAIL reset_c_outputs: got valid=%b ready=%b want 0/000", c_m_valid, c_s_ready);
    end
  endtask

  task automatic test_single_packet();
    a_m_ready = 1'b1;
    a_s_valid = 4'b0100;
    a_s_last  = 4'b0000;
    a_s_data[64 +: 32] = 32'hA0;
    tick();
    checks++; if (a_s_ready !== 4'b0100) begin errors++; $display("FAIL single_grant_ready: got %b want 0100", a_s_ready); end
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL single_bubble: got %b want 0", a_m_valid); end
    for (int k = 0; k < 3; k++) begin
      a_s_data[64 +: 32] = 32'hA0 + 32'(k);
      a_s_last[2] = (k == 2);
      tick();
      checks++;
      if (a_m_valid !== 1'b1 || a_m_data !== 32'hA0 + 32'(k) || a_m_sel !== 2'd2 ||
          a_m_last !== (k == 2)) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b d=%h sel=%0d last=%b want v=1 d=%h sel=2 last=%b",
                 k, a_m_valid, a_m_data, a_m_sel, a_m_last, 32'hA0 + 32'(k), (k == 2));
      end
    end
    a_s_valid = '0;
    a_s_last  = '0;
    checks++; if (a_busy !== 1'b0 || a_s_ready !== 4'b0) begin
      errors++; $display("FAIL single_release: got busy=%b ready=%b want 0/0000", a_busy, a_s_ready);
    end
    tick();
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", a_m_valid); end
    // Pointer now sits at 3, so port 3 beats port 0.
    a_s_valid = 4'b1001;
    tick();
    checks++; if (a_s_ready !== 4'b1000) begin errors++; $display("FAIL single_ptr3: got %b want 1000", a_s_ready); end
  endtask

  task automatic test_fairness();
    int cnt [4];
    int beat;
    logic [3:0] pre;
    logic exp_mv;
    logic [1:0] exp_sel;
    logic [31:0] exp_data;
    apply_reset();
    a_m_ready = 1'b1;
    a_s_valid = 4'b1111;
    beat = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      a_s_data[i*32 +: 32] = 32'(i * 16);
      a_s_last[i] = 1'b0;
    end
    for (int t = 1; t <= 15; t++) begin
      pre = a_s_ready;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (pre[i]) cnt[i]++;
        a_s_data[i*32 +: 32] = 32'(i * 16 + cnt[i]);
        a_s_last[i] = (cnt[i] % 2 == 1);
      end
      exp_mv = (t >= 2) && ((t - 2) % 3 != 2);
      checks++;
      if (a_m_valid !== exp_mv) begin
        errors++; $display("FAIL fair_valid_t%0d: got %b want %b", t, a_m_valid, exp_mv);
      end
      if (exp_mv && beat < 10) begin
        exp_sel  = 2'((beat / 2) % 4);
        exp_data = 32'(int'(exp_sel) * 16 + 2 * (beat / 8) + beat % 2);
        checks++;
        if (a_m_sel !== exp_sel || a_m_data !== exp_data || a_m_last !== (beat % 2 == 1)) begin
          errors++;
          $display("FAIL fair_beat%0d: got sel=%0d d=%h last=%b want sel=%0d d=%h last=%b",
                   beat, a_m_sel, a_m_data, a_m_last, exp_sel, exp_data, (beat % 2 == 1));
        end
        beat++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [$];
    logic [31:0] exp, md;
    logic [3:0] pre_rdy;
    logic pre_take, ml;
    logic [1:0] ms;
    int n0, n1, popped, skid_seen;
    apply_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back(32'h100 + 32'(k));
    for (int k = 0; k < 2; k++) exp_q.push_back(32'(k));
    n0 = 0; n1 = 0; popped = 0; skid_seen = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      a_s_valid[1] = (n1 < 6);
      a_s_data[32 +: 32] = 32'h100 + 32'(n1);
      a_s_last[1] = (n1 == 5);
      a_s_valid[0] = (cyc >= 1) && (n0 < 2);
      a_s_data[0 +: 32] = 32'(n0);
      a_s_last[0] = (n0 == 1);
      checks++;
      if (!$onehot0(a_s_ready) || (n1 < 6 && a_s_ready[0])) begin
        errors++; $display("FAIL bp_ready_cyc%0d: got %b want port-1-only or idle", cyc, a_s_ready);
      end
      if (a_busy && a_s_ready == 4'b0) skid_seen++;
      pre_rdy  = a_s_ready;
      pre_take = a_m_valid & a_m_ready;
      md = a_m_data; ml = a_m_last; ms = a_m_sel;
      tick();
      if (pre_rdy[1] && a_s_valid[1]) n1++;
      if (pre_rdy[0] && a_s_valid[0]) n0++;
      if (pre_take) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_beat: got d=%h want no beat", md);
        end else begin
          exp = exp_q.pop_front();
          popped++;
          if (md !== exp || ms !== (exp[8] ? 2'd1 : 2'd0) ||
              ml !== (exp == 32'h105 || exp == 32'h1)) begin
            errors++;
            $display("FAIL bp_beat%0d: got d=%h sel=%0d last=%b want d=%h", popped, md, ms, ml, exp);
          end
        end
      end
    end
    checks++; if (popped != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count: got %0d beats want 8", popped);
    end
    checks++; if (skid_seen == 0) begin
      errors++; $display("FAIL bp_skid_full: got 0 skid-full cycles want >0");
    end
    a_s_valid = '0;
  endtask

  task automatic test_lock0();
    int cnt [4];
    int nb;
    logic [3:0] pre;
    logic [1:0] exp_sel;
    logic [31:0] exp_data;
    apply_reset();
    b_m_ready = 1'b1;
    b_s_valid = 4'b1001;
    cnt[0] = 0; cnt[3] = 0; nb = 0;
    b_s_data[0 +: 32]  = 32'h0;
    b_s_data[96 +: 32] = 32'h30;
    for (int t = 1; t <= 12; t++) begin
      pre = b_s_ready;
      tick();
      if (pre[0]) cnt[0]++;
      if (pre[3]) cnt[3]++;
      b_s_data[0 +: 32]  = 32'(cnt[0]);
      b_s_data[96 +: 32] = 32'(48 + cnt[3]);
      if (b_m_valid && nb < 4) begin
        exp_sel  = (nb % 2 == 0) ? 2'd0 : 2'd3;
        exp_data = 32'(int'(exp_sel) * 16 + nb / 2);
        checks++;
        if (b_m_sel !== exp_sel || b_m_data !== exp_data) begin
          errors++; $display("FAIL lock0_beat%0d: got sel=%0d d=%h want sel=%0d d=%h",
                             nb, b_m_sel, b_m_data, exp_sel, exp_data);
        end
        nb++;
      end
    end
    checks++; if (nb != 4) begin errors++; $display("FAIL lock0_count: got %0d want 4", nb); end
    b_s_valid = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a_m_ready = 1'b1;
    a_s_valid = 4'b0100;
    a_s_last  = 4'b0100;
    a_s_data[64 +: 32] = 32'hC2;
    tick();
    tick();
    a_s_valid = 4'b0010;
    a_s_last  = 4'b0000;
    a_s_data[32 +: 32] = 32'hB0;
    a_m_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (a_m_valid !== 1'b1 || a_s_ready !== 4'b0 || a_busy !== 1'b1 || a_m_data !== 32'hC2) begin
      errors++; $display("FAIL rmid_skid_full: got v=%b rdy=%b busy=%b d=%h want 1/0000/1/c2",
                         a_m_valid, a_s_ready, a_busy, a_m_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (a_m_valid !== 1'b0 || a_s_ready !== 4'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL rmid_after_reset: got v=%b rdy=%b busy=%b want 0/0000/0",
                         a_m_valid, a_s_ready, a_busy);
    end
    a_s_valid = 4'b1011;
    a_s_data[0 +: 32] = 32'hD0;
    a_m_ready = 1'b1;
    tick();
    checks++; if (a_s_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr0: got %b want 0001", a_s_ready); end
    tick();
    checks++;
    if (a_m_valid !== 1'b1 || a_m_data !== 32'hD0 || a_m_sel !== 2'd0) begin
      errors++; $display("FAIL rmid_first_beat: got v=%b d=%h sel=%0d want 1/d0/0",
                         a_m_valid, a_m_data, a_m_sel);
    end
    a_s_valid = '0;
  endtask

  task automatic test_wrap();
    int nb;
    logic [1:0] exp_sel;
    apply_reset();
    c_m_ready = 1'b1;
    c_s_last  = 3'b111;
    for (int i = 0; i < 3; i++) c_s_data[i*32 +: 32] = 32'hE0 + 32'(i);
    c_s_valid = 3'b100;
    tick();
    tick();
    checks++;
    if (c_m_valid !== 1'b1 || c_m_sel !== 2'd2 || c_m_data !== 32'hE2) begin
      errors++; $display("FAIL wrap_first: got v=%b sel=%0d d=%h want 1/2/e2", c_m_valid, c_m_sel, c_m_data);
    end
    c_s_valid = 3'b101;
    tick();
    checks++; if (c_s_ready !== 3'b001) begin errors++; $display("FAIL wrap_grant0: got %b want 001", c_s_ready); end
    nb = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (c_m_valid) begin
        exp_sel = (nb % 2 == 0) ? 2'd0 : 2'd2;
        checks++;
        if (c_m_sel !== exp_sel || c_m_data !== 32'hE0 + 32'(exp_sel)) begin
          errors++; $display("FAIL wrap_beat%0d: got sel=%0d d=%h want sel=%0d", nb, c_m_sel, c_m_data, exp_sel);
        end
        nb++;
      end
    end
    checks++; if (nb != 5) begin errors++; $display("FAIL wrap_count: got %0d want 5", nb); end
    c_s_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fairness();
    test_backpressure();
    test_lock0();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin N:1 stream arbiter/mux. Shares one downstream valid/ready stream consumer, e.g. a DMA or packer, between NUM_PORTS upstream sources.
- Grants are packet-locked, so a granted source holds the output until its last beat.
- The output has a registered flip-flop stage with a one-entry skid register. All outputs are registered and s_ready does not depend combinationally on m_ready.

Parameters:
- NUM_PORTS, 4, number of requesting slave ports (2..16).
- DSIZE, 32, data width per beat.
- LOCK_PACKET, 1. 1 = hold grant until an accepted beat with s_last. 0 = re-arbitrate after every accepted beat.
- SEL_W, $clog2(NUM_PORTS), width of the source index.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  NUM_PORTS  per-port beat valid.
- s_ready  out  NUM_PORTS  per-port ready; at most one bit high in any cycle.
- s_data  in  NUM_PORTS*DSIZE  port i occupies bits [i*DSIZE +: DSIZE].
- s_last  in  NUM_PORTS  per-port end-of-packet.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DSIZE  output beat.
- m_last  out  1  end-of-packet, copied from the source beat.
- m_sel  out  SEL_W  index of the port that produced the current m_data.
- busy  out  1  high while a grant is held (state GRANT).

Behaviour:
- Reset (reset=1 at a clock edge): state=IDLE, ptr=0, grant=0, m_valid=0, skid_valid=0, s_ready=0, busy=0. m_data, m_last and m_sel are don't-care but must not be X-propagated into m_valid.
- Reset mid-packet aborts the packet. The partial beats already emitted are not completed and any skid contents are dropped.
- Beat transfer occurs when a valid/ready pair are both high at a clock edge.
- FSM states: IDLE and GRANT.
- IDLE:
  - If any s_valid is high, grant = first index j with s_valid[j]=1, scanning ptr, ptr+1, ... NUM_PORTS-1, 0, ... with wrap.
  - Register grant and move to GRANT next cycle. s_ready stays 0 in IDLE, so the arbitration bubble is 1 cycle.
  - If no s_valid is high, stay in IDLE.
- GRANT:
  - s_ready[grant] = ~skid_valid; all other s_ready bits are 0.
  - On an accepted beat with (s_last[grant] or LOCK_PACKET=0): move to IDLE and set ptr <= (grant+1) mod NUM_PORTS.
  - Otherwise stay in GRANT. A granted port that drops s_valid mid-packet keeps the grant indefinitely; there is no timeout.
- Output stage, equivalent to a pipeline flip-flop with skid:
  - advance = ~m_valid | m_ready.
  - On advance: m_valid <= skid_valid | accepted; m_data/m_last/m_sel load from skid if skid_valid, else from the accepted beat; then skid_valid <= 0.
  - On an accepted beat while not advance: capture the beat into skid and set skid_valid <= 1. s_ready therefore drops the next cycle.
- Latency: a beat accepted at edge t is presented at edge t+1 when the output is empty.
- Throughput: 1 beat/cycle inside a packet while m_ready=1.
- Ordering: beats from one port are never reordered. Packets from different ports are never interleaved when LOCK_PACKET=1.
- Simultaneous events: the last beat is accepted in the same cycle that other ports raise s_valid. The new grant is computed in the following IDLE cycle using the updated ptr.
- Backpressure: with m_ready=0 for many cycles, at most 2 beats are held (m + skid) and s_ready=0 afterward. No beat is lost or duplicated.
- Fairness: with all ports continuously requesting, grants cycle 0,1,2,...,N-1,0.
- Non-power-of-2 NUM_PORTS: ptr wraps at NUM_PORTS-1 to 0, and indices >= NUM_PORTS are never granted.

Test Plan:
- Reset, then port 2 sends a 3-beat packet (A0..A2, last on A2) with m_ready=1 → s_ready[2] high from cycle 2; m_data A0,A1,A2 on consecutive cycles with m_sel=2 and m_last only on A2; ptr=3 afterward.
- All 4 ports request continuous 2-beat packets with m_ready=1 → m_sel sequence 0,0,1,1,2,2,3,3,0,0, with one idle output cycle between packets.
- Port 1 is mid-packet while port 0 requests; m_ready toggles 1,0,0,1 → m_data carries only port-1 beats until the port-1 last beat. Skid fills, s_ready[1]=0 while the skid is full, and no beat is dropped or duplicated (scoreboard).
- LOCK_PACKET=0, ports 0 and 3 stream continuously → grants alternate per beat: m_sel 0,3,0,3.
- Reset asserted for 1 cycle mid-packet with m_valid=1 and the skid full → the next cycle shows m_valid=0, s_ready=0, busy=0, and the following arbitration starts from port 0.
- NUM_PORTS=3, ports 0 and 2 request after a grant to port 2 → next grant is port 0 (wrap); port index 3 is never selected.
